// File: rtl/issue_queue_sel.sv
// Centralised issue queue: one dispatch per cycle, tag-broadcast wakeup and NUM_FU
// independent oldest-ready select channels with valid/ready handshake to the FUs.
module issue_queue_sel #(
  parameter int DEPTH        = 16,
  parameter int PRF_WIDTH    = 6,
  parameter int OPCODE_WIDTH = 7,
  parameter int NUM_FU       = 4,
  parameter int WB_PORTS     = 4,
  parameter int AGE_WIDTH    = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            disp_valid,
  output logic                            disp_ready,
  input  logic [OPCODE_WIDTH-1:0]         disp_op,
  input  logic [NUM_FU-1:0]               disp_fu_mask,
  input  logic [PRF_WIDTH-1:0]            disp_prs1,
  input  logic [PRF_WIDTH-1:0]            disp_prs2,
  input  logic                            disp_prs1_v,
  input  logic                            disp_prs2_v,
  input  logic                            disp_prs1_rdy,
  input  logic                            disp_prs2_rdy,
  input  logic [PRF_WIDTH-1:0]            disp_prd,
  input  logic                            disp_prdv,
  input  logic [WB_PORTS-1:0]             wb_valid,
  input  logic [WB_PORTS*PRF_WIDTH-1:0]   wb_tag,
  output logic [NUM_FU-1:0]               iss_valid,
  input  logic [NUM_FU-1:0]               iss_ready,
  output logic [NUM_FU*OPCODE_WIDTH-1:0]  iss_op,
  output logic [NUM_FU*PRF_WIDTH-1:0]     iss_prs1,
  output logic [NUM_FU*PRF_WIDTH-1:0]     iss_prs2,
  output logic [NUM_FU*PRF_WIDTH-1:0]     iss_prd,
  output logic [NUM_FU-1:0]               iss_prdv,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = {AGE_WIDTH{1'b1}};

  logic [DEPTH-1:0]        valid_q, p1v_q, p1r_q, p2v_q, p2r_q, prdv_q;
  logic [OPCODE_WIDTH-1:0] op_q   [DEPTH];
  logic [NUM_FU-1:0]       mask_q [DEPTH];
  logic [PRF_WIDTH-1:0]    prs1_q [DEPTH];
  logic [PRF_WIDTH-1:0]    prs2_q [DEPTH];
  logic [PRF_WIDTH-1:0]    prd_q  [DEPTH];
  logic [AGE_WIDTH-1:0]    age_q  [DEPTH];
  logic [OCC_W-1:0]        occ_q;

  logic [DEPTH-1:0]  wake1, wake2, ready_vec, taken, clr;
  logic              disp_wake1, disp_wake2, disp_acc;
  logic [IDX_W-1:0]  free_idx;
  logic [NUM_FU-1:0] sel_valid, issue_acc;
  logic [IDX_W-1:0]  pick [NUM_FU];
  logic [OCC_W-1:0]  n_iss;

  // Tag compare against every entry and the incoming dispatch, so a broadcast
  // in the dispatch cycle is not lost.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wake1      = '0;
    wake2      = '0;
    disp_wake1 = 1'b0;
    disp_wake2 = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p]) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (wb_tag[p*PRF_WIDTH +: PRF_WIDTH] == prs1_q[e]) wake1[e] = 1'b1;
          if (wb_tag[p*PRF_WIDTH +: PRF_WIDTH] == prs2_q[e]) wake2[e] = 1'b1;
        end
        if (wb_tag[p*PRF_WIDTH +: PRF_WIDTH] == disp_prs1) disp_wake1 = 1'b1;
        if (wb_tag[p*PRF_WIDTH +: PRF_WIDTH] == disp_prs2) disp_wake2 = 1'b1;
      end
    end
  end

  assign ready_vec = valid_q & (~p1v_q | p1r_q) & (~p2v_q | p2r_q);

  always_comb begin : select
    logic                 found;
    logic [AGE_WIDTH-1:0] best_age;
    logic [IDX_W-1:0]     best;
    taken     = '0;
    sel_valid = '0;
    for (int c = 0; c < NUM_FU; c++) begin
      pick[c]  = '0;
      found    = 1'b0;
      best_age = '0;
      best     = '0;
      // Strict '>' while scanning upward keeps the lowest index on an age tie.
      for (int e = 0; e < DEPTH; e++) begin
        if (ready_vec[e] && mask_q[e][c] && !taken[e] && (!found || age_q[e] > best_age)) begin
          found    = 1'b1;
          best_age = age_q[e];
          best     = IDX_W'(e);
        end
      end
      if (found) begin
        taken[best]  = 1'b1;
        sel_valid[c] = 1'b1;
        pick[c]      = best;
      end
    end
  end

  always_comb begin
    iss_op   = '0;
    iss_prs1 = '0;
    iss_prs2 = '0;
    iss_prd  = '0;
    iss_prdv = '0;
    for (int c = 0; c < NUM_FU; c++) begin
      iss_op  [c*OPCODE_WIDTH +: OPCODE_WIDTH] = op_q[pick[c]];
      iss_prs1[c*PRF_WIDTH +: PRF_WIDTH]       = prs1_q[pick[c]];
      iss_prs2[c*PRF_WIDTH +: PRF_WIDTH]       = prs2_q[pick[c]];
      iss_prd [c*PRF_WIDTH +: PRF_WIDTH]       = prd_q[pick[c]];
      iss_prdv[c]                              = prdv_q[pick[c]];
    end
  end

  assign iss_valid = sel_valid & {NUM_FU{rst_n}};
  assign issue_acc = iss_valid & iss_ready;

  always_comb begin
    clr   = '0;
    n_iss = '0;
    for (int c = 0; c < NUM_FU; c++) begin
      if (issue_acc[c]) begin
        clr[pick[c]] = 1'b1;
        n_iss        = n_iss + OCC_W'(1);
      end
    end
  end

  // Downward scan so the lowest free index is the one left standing.
  always_comb begin
    free_idx = '0;
    for (int e = DEPTH-1; e >= 0; e--) begin
      if (!valid_q[e]) free_idx = IDX_W'(e);
    end
  end

  assign disp_ready = rst_n & (occ_q < OCC_W'(DEPTH));
  assign disp_acc   = disp_valid & disp_ready & ~flush;
  assign occupancy  = occ_q;

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_q & ~clr;
      if (disp_acc) valid_q[free_idx] <= 1'b1;
      occ_q <= occ_q + OCC_W'(disp_acc) - n_iss;
    end
  end

  // NOTE: entry payload is not reset; valid_q alone decides whether it means anything.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (valid_q[e]) begin
        if (age_q[e] != AGE_MAX) age_q[e] <= age_q[e] + 1'b1;
        if (wake1[e]) p1r_q[e] <= 1'b1;
        if (wake2[e]) p2r_q[e] <= 1'b1;
      end
    end
    if (disp_acc) begin
      op_q  [free_idx] <= disp_op;
      mask_q[free_idx] <= disp_fu_mask;
      prs1_q[free_idx] <= disp_prs1;
      prs2_q[free_idx] <= disp_prs2;
      prd_q [free_idx] <= disp_prd;
      prdv_q[free_idx] <= disp_prdv;
      p1v_q [free_idx] <= disp_prs1_v;
      p2v_q [free_idx] <= disp_prs2_v;
      p1r_q [free_idx] <= disp_prs1_rdy | disp_wake1;
      p2r_q [free_idx] <= disp_prs2_rdy | disp_wake2;
      age_q [free_idx] <= '0;
    end
  end

endmodule

// File: tb/tb_issue_queue_sel.sv
// Randomised and directed bench for issue_queue_sel: a behavioural queue model predicts
// each cycle's outputs into a scoreboard that a separate monitor drains and compares.
module tb_issue_queue_sel;

  localparam int DEPTH = 16;
  localparam int PW    = 6;
  localparam int OW    = 7;
  localparam int NF    = 4;
  localparam int WB    = 4;
  localparam int AW    = 5;
  localparam int AMAX  = 31;
  localparam int OCCW  = $clog2(DEPTH+1);

  logic              clk, rst_n, flush, disp_valid, disp_ready;
  logic [OW-1:0]     disp_op;
  logic [NF-1:0]     disp_fu_mask;
  logic [PW-1:0]     disp_prs1, disp_prs2, disp_prd;
  logic              disp_prs1_v, disp_prs2_v, disp_prs1_rdy, disp_prs2_rdy, disp_prdv;
  logic [WB-1:0]     wb_valid;
  logic [WB*PW-1:0]  wb_tag;
  logic [NF-1:0]     iss_valid, iss_ready, iss_prdv;
  logic [NF*OW-1:0]  iss_op;
  logic [NF*PW-1:0]  iss_prs1, iss_prs2, iss_prd;
  logic [OCCW-1:0]   occupancy;

  issue_queue_sel #(
    .DEPTH(DEPTH), .PRF_WIDTH(PW), .OPCODE_WIDTH(OW),
    .NUM_FU(NF), .WB_PORTS(WB), .AGE_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_fu_mask(disp_fu_mask), .disp_prs1(disp_prs1), .disp_prs2(disp_prs2),
    .disp_prs1_v(disp_prs1_v), .disp_prs2_v(disp_prs2_v),
    .disp_prs1_rdy(disp_prs1_rdy), .disp_prs2_rdy(disp_prs2_rdy),
    .disp_prd(disp_prd), .disp_prdv(disp_prdv),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_prs1(iss_prs1), .iss_prs2(iss_prs2), .iss_prd(iss_prd), .iss_prdv(iss_prdv),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model entry: age is derived from the edge on which it was dispatched.
  typedef struct {
    bit          valid;
    logic [OW-1:0] op;
    logic [NF-1:0] mask;
    logic [PW-1:0] s1, s2, d;
    bit          s1v, s1r, s2v, s2r, dv;
    int          birth;
  } ent_t;

  typedef struct {
    logic            drdy;
    logic [NF-1:0]   ivld;
    int              occ;
    logic [NF*OW-1:0] op;
    logic [NF*PW-1:0] p1, p2, pd;
    logic [NF-1:0]   pdv;
  } exp_t;

  ent_t m [DEPTH];
  exp_t sbq [$];
  int   pick_m [NF];
  int   edge_n = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int age_of(int i);
    int a;
    a = edge_n - m[i].birth;
    return (a > AMAX) ? AMAX : a;
  endfunction

  function automatic bit ent_ready(int i);
    return m[i].valid && (!m[i].s1v || m[i].s1r) && (!m[i].s2v || m[i].s2r);
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].valid) n++;
    return n;
  endfunction

  function automatic bit wb_hits(logic [PW-1:0] t);
    for (int p = 0; p < WB; p++)
      if (wb_valid[p] && wb_tag[p*PW +: PW] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Oldest eligible entry per channel, channels in priority order.
  function automatic void model_select();
    bit taken [DEPTH];
    for (int i = 0; i < DEPTH; i++) taken[i] = 1'b0;
    for (int c = 0; c < NF; c++) begin
      int best = -1;
      for (int i = 0; i < DEPTH; i++)
        if (ent_ready(i) && m[i].mask[c] && !taken[i])
          if (best < 0 || age_of(i) > age_of(best)) best = i;
      pick_m[c] = best;
      if (best >= 0) taken[best] = 1'b1;
    end
  endfunction

  // Predict this cycle's outputs, advance the model across the edge, move to next negedge.
  task automatic tick();
    exp_t x;
    int   free_i;
    bit   clr [DEPTH];
    model_select();
    x.occ  = model_count();
    x.drdy = rst_n && (x.occ < DEPTH);
    x.ivld = '0; x.op = '0; x.p1 = '0; x.p2 = '0; x.pd = '0; x.pdv = '0;
    for (int c = 0; c < NF; c++) begin
      if (rst_n && pick_m[c] >= 0) begin
        x.ivld[c]          = 1'b1;
        x.op[c*OW +: OW]   = m[pick_m[c]].op;
        x.p1[c*PW +: PW]   = m[pick_m[c]].s1;
        x.p2[c*PW +: PW]   = m[pick_m[c]].s2;
        x.pd[c*PW +: PW]   = m[pick_m[c]].d;
        x.pdv[c]           = m[pick_m[c]].dv;
      end
    end
    sbq.push_back(x);

    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) m[i].valid = 1'b0;
    end else begin
      free_i = -1;
      for (int i = 0; i < DEPTH; i++) begin
        clr[i] = 1'b0;
        if (!m[i].valid && free_i < 0) free_i = i;
      end
      for (int c = 0; c < NF; c++)
        if (pick_m[c] >= 0 && iss_ready[c]) clr[pick_m[c]] = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (m[i].valid) begin
          if (m[i].s1v && wb_hits(m[i].s1)) m[i].s1r = 1'b1;
          if (m[i].s2v && wb_hits(m[i].s2)) m[i].s2r = 1'b1;
          if (clr[i]) m[i].valid = 1'b0;
        end
      end
      if (disp_valid && x.drdy) begin
        m[free_i].valid = 1'b1;
        m[free_i].op    = disp_op;
        m[free_i].mask  = disp_fu_mask;
        m[free_i].s1    = disp_prs1;
        m[free_i].s2    = disp_prs2;
        m[free_i].d     = disp_prd;
        m[free_i].dv    = disp_prdv;
        m[free_i].s1v   = disp_prs1_v;
        m[free_i].s2v   = disp_prs2_v;
        m[free_i].s1r   = disp_prs1_rdy || wb_hits(disp_prs1);
        m[free_i].s2r   = disp_prs2_rdy || wb_hits(disp_prs2);
        m[free_i].birth = edge_n + 1;
      end
    end
    edge_n++;
    @(negedge clk);
  endtask

  task automatic drive_disp(input logic [OW-1:0] op, input logic [NF-1:0] mask,
                            input logic [PW-1:0] s1, input logic s1v, input logic s1r,
                            input logic [PW-1:0] s2, input logic s2v, input logic s2r);
    disp_valid    = 1'b1;
    disp_op       = op;
    disp_fu_mask  = mask;
    disp_prs1     = s1;
    disp_prs1_v   = s1v;
    disp_prs1_rdy = s1r;
    disp_prs2     = s2;
    disp_prs2_v   = s2v;
    disp_prs2_rdy = s2r;
    disp_prd      = s1 ^ s2 ^ 6'h2a;
    disp_prdv     = op[0];
  endtask

  task automatic idle(input int n);
    disp_valid = 1'b0;
    wb_valid   = '0;
    flush      = 1'b0;
    repeat (n) tick();
  endtask

  // Monitor: drains one prediction per cycle, after inputs have settled.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        check("disp_ready", 32'(disp_ready), 32'(x.drdy));
        check("occupancy",  32'(occupancy),  32'(x.occ));
        check("iss_valid",  32'(iss_valid),  32'(x.ivld));
        for (int c = 0; c < NF; c++) begin
          if (x.ivld[c]) begin
            check($sformatf("iss_op[%0d]", c),   32'(iss_op[c*OW +: OW]),   32'(x.op[c*OW +: OW]));
            check($sformatf("iss_prs1[%0d]", c), 32'(iss_prs1[c*PW +: PW]), 32'(x.p1[c*PW +: PW]));
            check($sformatf("iss_prs2[%0d]", c), 32'(iss_prs2[c*PW +: PW]), 32'(x.p2[c*PW +: PW]));
            check($sformatf("iss_prd[%0d]", c),  32'(iss_prd[c*PW +: PW]),  32'(x.pd[c*PW +: PW]));
            check($sformatf("iss_prdv[%0d]", c), 32'(iss_prdv[c]),          32'(x.pdv[c]));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m[i].valid = 1'b0;
      m[i].birth = 0;
    end
    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; iss_ready = '0;
    wb_valid = '0; wb_tag = '0;
    drive_disp('0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    disp_valid = 1'b0;
    @(negedge clk);

    // Reset held for three cycles, then released.
    repeat (3) tick();
    rst_n = 1'b1;
    idle(1);

    // Ready op straight through channel 0.
    iss_ready = '1;
    drive_disp(7'h33, 4'b0001, 6'd1, 1'b1, 1'b1, 6'd2, 1'b1, 1'b1);
    tick();
    idle(2);

    // Wakeup: prs1=5 waits for a broadcast of tag 5.
    drive_disp(7'h11, 4'b0001, 6'd5, 1'b1, 1'b0, 6'd9, 1'b0, 1'b0);
    tick();
    idle(2);
    wb_valid = 4'b0001;
    wb_tag   = 24'd5;
    tick();
    idle(2);

    // Age order across two channels.
    iss_ready = '0;
    drive_disp(7'h01, 4'b0011, 6'd1, 1'b1, 1'b1, 6'd2, 1'b0, 1'b0); tick();
    drive_disp(7'h02, 4'b0011, 6'd3, 1'b1, 1'b1, 6'd4, 1'b0, 1'b0); tick();
    drive_disp(7'h03, 4'b0011, 6'd5, 1'b1, 1'b1, 6'd6, 1'b0, 1'b0); tick();
    iss_ready = 4'b0011;
    idle(3);

    // Fill to capacity (17th dispatch is refused), free one, refill.
    iss_ready = '0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      drive_disp(OW'(k + 8), 4'b1111, PW'(k), 1'b1, 1'b1, PW'(k + 1), 1'b1, 1'b1);
      tick();
    end
    disp_valid = 1'b0;
    iss_ready  = 4'b0001;
    tick();
    iss_ready  = '0;
    drive_disp(7'h7f, 4'b0100, 6'd7, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0);
    tick();
    // Long backpressure: payload must hold and ages saturate into ties.
    idle(36);

    // Flush, with a dispatch attempt in the same cycle.
    flush = 1'b1;
    drive_disp(7'h44, 4'b1111, 6'd1, 1'b0, 1'b0, 6'd1, 1'b0, 1'b0);
    tick();
    idle(2);

    // Randomised traffic with occasional flush and one mid-run reset.
    for (int i = 0; i < 1500; i++) begin
      rst_n     = !(i >= 700 && i < 702);
      flush     = ($urandom_range(0, 99) == 0);
      iss_ready = NF'($urandom);
      wb_valid  = WB'($urandom);
      for (int p = 0; p < WB; p++) wb_tag[p*PW +: PW] = PW'($urandom_range(0, 7));
      drive_disp(OW'($urandom), NF'($urandom_range(1, 15)),
                 PW'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                 PW'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 2) == 0));
      disp_valid = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst_n = 1'b1;
    iss_ready = '1;
    idle(4);
    #2;
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
